// File: rtl/fp_pkg.sv
// Shared floating-point constants: field widths per word size, flag bit positions
// and canonical quiet-NaN encodings.
package fp_pkg;

   localparam int FLAG_INV = 2;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_UNF = 0;

   localparam int EXP_W_SP = 8;
   localparam int MAN_W_SP = 23;
   localparam int EXP_W_DP = 11;
   localparam int MAN_W_DP = 52;

   localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
   localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;

   typedef logic [2:0] fp_flags_t;

   function automatic int exp_width(input int x);
      return (x == 64) ? EXP_W_DP : EXP_W_SP;
   endfunction

   function automatic int man_width(input int x);
      return (x == 64) ? MAN_W_DP : MAN_W_SP;
   endfunction

   // Quiet NaN right-aligned in a 64-bit container; callers slice [x-1:0].
   function automatic logic [63:0] qnan(input int x);
      return (x == 64) ? QNAN_DP : {32'h0, QNAN_SP};
   endfunction

endpackage

// File: rtl/fp_result_queue_if.sv
// Producer/consumer bundle of the result queue: adder-side push port and
// consumer-side pop port. The queue itself uses the slave modport.
interface fp_result_queue_if #(
   parameter int X = 32
);
   import fp_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [X-1:0] in_result;
   logic         in_overflow;
   logic         in_underflow;
   logic         out_valid;
   logic         out_ready;
   logic [X-1:0] out_result;
   fp_flags_t    out_flags;

   modport master (
      output in_valid, in_result, in_overflow, in_underflow, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_result, in_overflow, in_underflow, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );

endinterface

// File: rtl/fp_fixup.sv
// Combinational IEEE-754 special-value fix-up of an adder result.
// Optional NaN canonicalisation under FP_RESULT_Q_NAN_CANON_EN.
module fp_fixup
   import fp_pkg::*;
#(
   parameter int X = 32
) (
   input  logic [X-1:0] word,
   input  logic         overflow,
   input  logic         underflow,
   output logic [X-1:0] fixed,
   output fp_flags_t    flags
);

   localparam int EW = exp_width(X);
   localparam int MW = man_width(X);

   logic sign;
   assign sign = word[X-1];

`ifdef FP_RESULT_Q_NAN_CANON_EN
   localparam logic [63:0] QNAN_W = qnan(X);
   logic [EW-1:0] exp_f;
   logic [MW-1:0] man_f;
   assign exp_f = word[X-2 -: EW];
   assign man_f = word[MW-1:0];
`endif

   // Overflow outranks underflow when the adder reports both.
   always_comb begin
      fixed = word;
      flags = '0;
      if (overflow) begin
         fixed          = {sign, {EW{1'b1}}, {MW{1'b0}}};
         flags[FLAG_OVF] = 1'b1;
      end else if (underflow) begin
         fixed          = {sign, {(X-1){1'b0}}};
         flags[FLAG_UNF] = 1'b1;
      end
`ifdef FP_RESULT_Q_NAN_CANON_EN
      else if ((&exp_f) && (|man_f)) begin
         fixed          = QNAN_W[X-1:0];
         flags[FLAG_INV] = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/fp_result_queue.sv
// Registered result queue behind the FP adder: fix-up at push, in-order FIFO,
// sticky exception flags. FP_RESULT_Q_NAN_CANON_EN enables NaN canonicalisation.
module fp_result_queue
   import fp_pkg::*;
#(
   parameter int X     = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fp_result_queue_if.slave          bus,
   output logic [$clog2(DEPTH):0]    count,
   input  logic                      clear_flags,
   output fp_flags_t                 sticky_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [X-1:0]    mem_reg [DEPTH];
   fp_flags_t       flag_mem_reg [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   count_next;
   fp_flags_t       sticky_reg;
   logic [X-1:0]    fixed_word;
   fp_flags_t       fixed_flags;
   logic            push;
   logic            pop;

   fp_fixup #(.X(X)) u_fixup (
      .word      (bus.in_result),
      .overflow  (bus.in_overflow),
      .underflow (bus.in_underflow),
      .fixed     (fixed_word),
      .flags     (fixed_flags)
   );

   // Ready and valid come only from the registered count, so nothing on the
   // input side reaches the outputs combinationally.
   assign bus.in_ready  = (count_reg != CW'(DEPTH));
   assign bus.out_valid = (count_reg != '0);
   assign bus.out_result = mem_reg[rd_ptr_reg];
   assign bus.out_flags  = flag_mem_reg[rd_ptr_reg];
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;
   assign count        = count_reg;
   assign sticky_flags = sticky_reg;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage is reset so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i]      <= '0;
            flag_mem_reg[i] <= '0;
         end
      end else if (push) begin
         mem_reg[wr_ptr_reg]      <= fixed_word;
         flag_mem_reg[wr_ptr_reg] <= fixed_flags;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // Clear takes effect before the set from a push in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_reg <= '0;
      end else if (clear_flags) begin
         sticky_reg <= push ? fixed_flags : '0;
      end else if (push) begin
         sticky_reg <= sticky_reg | fixed_flags;
      end
   end

endmodule

// File: tb/tb_fp_result_queue.sv
// Directed self-checking bench for fp_result_queue (X=32, DEPTH=4).
// NaN expectations follow FP_RESULT_Q_NAN_CANON_EN.
module tb_fp_result_queue;
   import fp_pkg::*;

   localparam int X     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear_flags = 1'b0;
   logic [CW-1:0] count;
   fp_flags_t     sticky_flags;
   int            vectors = 0;
   int            miscompares = 0;

   fp_result_queue_if #(.X(X)) bus ();

   fp_result_queue #(.X(X), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .count        (count),
      .clear_flags  (clear_flags),
      .sticky_flags (sticky_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic ovf,
                        input logic unf, input logic ordy);
      bus.in_valid     = v;
      bus.in_result    = r;
      bus.in_overflow  = ovf;
      bus.in_underflow = unf;
      bus.out_ready    = ordy;
   endtask

   initial begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Reset state
      #2;
      check("rst_count", count, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_sticky", sticky_flags, 0);
      check("rst_out_result", bus.out_result, 0);
      check("rst_out_flags", bus.out_flags, 0);
      step();
      rst_n = 1'b1;

      // Overflow fix-up
      drive(1'b1, 32'h0012_3456, 1'b1, 1'b0, 1'b0);
      step();
      check("ovf_count", count, 1);
      check("ovf_valid", bus.out_valid, 1);
      check("ovf_result", bus.out_result, 32'h7F80_0000);
      check("ovf_flags", bus.out_flags, 3'b010);
      check("ovf_sticky", sticky_flags, 3'b010);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      check("ovf_pop_count", count, 0);

      // Underflow fix-up, then clear coinciding with an overflow push
      drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0);
      step();
      check("unf_result", bus.out_result, 32'h8000_0000);
      check("unf_flags", bus.out_flags, 3'b001);
      check("unf_sticky", sticky_flags, 3'b011);
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("clr_push_sticky", sticky_flags, 3'b010);
      check("clr_push_count", count, 1);
      check("both_result", bus.out_result, 32'hFF80_0000);
      check("both_flags", bus.out_flags, 3'b010);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      check("clr_drain_count", count, 0);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("clr_only_sticky", sticky_flags, 0);

      // Fill to DEPTH, refuse a fifth word, then drain in order
      drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h4080_0000, 1'b0, 1'b0, 1'b0); step();
      check("full_count", count, 4);
      check("full_in_ready", bus.in_ready, 0);
      drive(1'b1, 32'h40A0_0000, 1'b0, 1'b0, 1'b0);
      step();
      check("full_no_push_count", count, 4);
      check("full_head0", bus.out_result, 32'h3F80_0000);
      drive(1'b1, 32'h40A0_0000, 1'b0, 1'b0, 1'b1);
      step();
      check("full_pop_no_push_count", count, 3);
      check("drain_head1", bus.out_result, 32'h4000_0000);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      check("drain_head2", bus.out_result, 32'h4040_0000);
      step();
      check("drain_head3", bus.out_result, 32'h4080_0000);
      step();
      check("drain_empty_count", count, 0);
      check("drain_empty_valid", bus.out_valid, 0);

      // Steady push+pop at count=2 across several pointer wraps
      drive(1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h1000_0001, 1'b0, 1'b0, 1'b0); step();
      check("stream_pre_count", count, 2);
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 32'h1000_0002 + k, 1'b0, 1'b0, 1'b1);
         check($sformatf("stream_head%0d", k), bus.out_result, 32'h1000_0000 + k);
         step();
         check($sformatf("stream_count%0d", k), count, 2);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      step();
      check("stream_drain_count", count, 0);

      // Asynchronous reset with three entries held
      drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0); step();
      drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("prerst_count", count, 3);
      check("prerst_sticky", sticky_flags, 3'b010);
      rst_n = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_in_ready", bus.in_ready, 1);
      check("arst_sticky", sticky_flags, 0);
      check("arst_out_result", bus.out_result, 0);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
      step();
      check("postrst_count", count, 1);
      check("postrst_head", bus.out_result, 32'h4040_0000);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      check("postrst_pop_count", count, 0);

      // NaN input
      drive(1'b1, 32'hFF80_0001, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef FP_RESULT_Q_NAN_CANON_EN
      check("nan_result", bus.out_result, 32'h7FC0_0000);
      check("nan_flags", bus.out_flags, 3'b100);
      check("nan_sticky", sticky_flags, 3'b100);
`else
      check("nan_result", bus.out_result, 32'hFF80_0001);
      check("nan_flags", bus.out_flags, 3'b000);
      check("nan_sticky", sticky_flags, 3'b000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fp_result_queue.md
# fp_result_queue

Registered output stage placed directly downstream of the combinational floating-point adder. Each cycle it may capture the adder's result word and its overflow/underflow indications, then apply IEEE-754 special-value fix-up (overflow becomes ±infinity, underflow becomes ±zero). Fixed-up results go into a small in-order FIFO that drains through a valid/ready handshake. Sticky exception flags accumulate across results until software clears them.

## Interface
- `X`, default 32: word width. Legal values are 32 (single) and 64 (double). Exponent width is 8 or 11; mantissa width is 23 or 52.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  adder result present this cycle.
- `in_ready`  out  1  queue can accept an entry.
- `in_result`  in  X  adder output word.
- `in_overflow`  in  1  adder exponent overflow.
- `in_underflow`  in  1  adder underflow.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_result`  out  X  head result after fix-up.
- `out_flags`  out  3  per-entry flags: [2] invalid (NaN), [1] overflow, [0] underflow.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `clear_flags`  in  1  synchronous clear of sticky flags.
- `sticky_flags`  out  3  OR of the flags of all entries pushed since the last clear or reset.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Fix-up is applied at push time, and the fixed-up value is what gets stored:
  - If overflow: `{sign, all-ones exponent, zero mantissa}`, flags 3'b010.
  - Else if underflow: `{sign, all-zero}`, flags 3'b001.
  - Else: the word passes through unchanged, flags 3'b000.
  - If both overflow and underflow are asserted, overflow wins; flags 3'b010.
- FIFO behaviour:
  - Read and write pointers wrap modulo DEPTH.
  - `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- `in_ready = (count != DEPTH)`. There is no push while full, even if a pop happens in the same cycle.
- Popping when empty cannot occur, because `out_valid = (count != 0)`. `out_result` and `out_flags` show the head entry and are don't-care while `out_valid` is 0.
- Sticky flags:
  - `sticky_flags` is updated to `sticky_flags | pushed_flags` on each push.
  - `clear_flags` drives it to 0.
  - If clear and push happen in the same cycle, the result is `pushed_flags`: the clear applies first, then the set.

## Timing
- Latency from push to visibility is 1 cycle: an entry pushed at edge N is presented with `out_valid=1` after edge N.
- There is no combinational path from input to output: `in_valid` and `in_result` never reach `out_*` combinationally.
- `in_ready` depends only on `count` (registered); it does not depend on `out_ready`.
- Sustained throughput is 1 result/cycle whenever 0 < `count` < DEPTH.
- Reset values: `count` 0, `out_valid` 0, `in_ready` 1, `sticky_flags` 0, `out_result` 0, `out_flags` 0, pointers 0.
- Reset mid-operation: all entries are discarded immediately and asynchronously. The first push after `rst_n` rises takes effect on the following edge.

## Configuration
- `FP_RESULT_Q_NAN_CANON_EN`, when defined:
  - Any non-overflow, non-underflow input with an all-ones exponent and a non-zero mantissa is replaced by the canonical quiet NaN: 0x7FC00000 for 32-bit, 0x7FF8000000000000 for 64-bit.
  - The sign is forced to 0 and flag [2] is set.
- When not defined: NaNs pass through unchanged, and flag [2] is tied 0 in both `out_flags` and `sticky_flags`.

## Structure
- Shared package `fp_pkg` holds:
  - exponent/mantissa width constants selected by X;
  - flag bit index constants (`FLAG_INV`, `FLAG_OVF`, `FLAG_UNF`);
  - quiet-NaN constants for both widths.
- One combinational sub-module, `fp_fixup`, maps (word, overflow, underflow) to (fixed word, flags). The FIFO storage, pointers, `count` and sticky logic live in the top level.

## Test plan
- Overflow, X=32: `in_result`=0x00123456 with `in_overflow`=1 → `out_result`=0x7F800000, `out_flags`=3'b010, `sticky_flags`=3'b010.
- Underflow, X=32: `in_result`=0x80000001 with `in_underflow`=1 → `out_result`=0x80000000, `out_flags`=3'b001. Then assert `clear_flags` on the same edge as a pushed overflow → `sticky_flags`=3'b010.
- Fill, DEPTH=4, `out_ready`=0: push 0x3F800000, 0x40000000, 0x40400000, 0x40800000 → `count`=4 and `in_ready`=0. A 5th `in_valid` is not accepted. Drain with `out_ready`=1 → the four words come out in order, one per cycle.
- Simultaneous push and pop at `count`=2 → `count` stays 2 and FIFO order is preserved across pointer wrap (run ≥ 10 cycles).
- Reset mid-operation with `count`=3 → `out_valid`=0 and `count`=0 immediately, before the next edge. `sticky_flags`=0 and `in_ready`=1.
- NaN input 0xFF800001, X=32:
  - With `FP_RESULT_Q_NAN_CANON_EN` defined → `out_result`=0x7FC00000, `out_flags`=3'b100.
  - Without it → 0xFF800001, `out_flags`=3'b000.
